// File: rtl/writeback_unit.sv
// Writeback stage: selects the result word, commits it to the architectural
// register file, serves the two decode read ports (optional write-through),
// exposes a WB forwarding tap, tracks the sticky halt state and counts
// retired instructions.
module writeback_unit #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wb_valid,
    input  logic        regWr,
    input  logic [4:0]  wsel,
    input  logic [1:0]  MemToReg,
    input  logic [31:0] dmemload,
    input  logic [31:0] portO,
    input  logic [31:0] luiValue,
    input  logic [31:0] pcp4,
    input  logic        halt,
    input  logic [5:0]  op_wb,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic [31:0] rdat1,
    output logic [31:0] rdat2,
    output logic        fwd_valid,
    output logic [4:0]  fwd_sel,
    output logic [31:0] fwd_data,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_halted;
    logic [31:0] r_retired;
    logic [31:0] r_regs [1:31];

    logic [31:0] w_wdat;
    logic        w_we;
    logic [31:1] w_wr_en;
    logic        w_unused_op;

    // The opcode is carried for observability only; halt detection uses the halt input.
    assign w_unused_op = ^op_wb;

    // Result select: 00 ALU, 01 load data, 10 LUI value, 11 link address.
    always_comb begin
        w_wdat = portO;
        case (MemToReg)
            2'b00: w_wdat = portO;
            2'b01: w_wdat = dmemload;
            2'b10: w_wdat = luiValue;
            2'b11: w_wdat = pcp4;
            default: w_wdat = portO;
        endcase
    end

    // A write commits only for a real, non-halted instruction targeting a nonzero register.
    assign w_we = wb_valid & regWr & ~r_halted & (wsel != 5'd0);

    // One-hot write enable per physical register; register 0 has no storage.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_we & (wsel == 5'(gi));
        end
    endgenerate

    // Register file storage, cleared asynchronously so an in-flight write is lost on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= w_wdat;
                end
            end
        end
    end

    // Read port 1: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        rdat1 = '0;
        if (rsel1 != 5'd0) begin
            if (BYPASS && w_we && (wsel == rsel1)) begin
                rdat1 = w_wdat;
            end else begin
                rdat1 = r_regs[rsel1];
            end
        end
    end

    // Read port 2: same priority as port 1 so equal selects return equal data.
    always_comb begin
        rdat2 = '0;
        if (rsel2 != 5'd0) begin
            if (BYPASS && w_we && (wsel == rsel2)) begin
                rdat2 = w_wdat;
            end else begin
                rdat2 = r_regs[rsel2];
            end
        end
    end

    // Halt FSM with the retire counter; HALT itself retires, then everything freezes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_RUN;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (wb_valid) begin
                        r_retired <= r_retired + 32'd1;
                    end
                    if (wb_valid && halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign fwd_valid = w_we;
    assign fwd_sel   = wsel;
    assign fwd_data  = w_wdat;
    assign halted    = r_halted;
    assign retired   = r_retired;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a write-through instance and a
// non-bypassing instance driven with the same stimulus.
module tb_writeback_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wb_valid, regWr, halt;
    logic [4:0]  wsel, rsel1, rsel2;
    logic [1:0]  MemToReg;
    logic [31:0] dmemload, portO, luiValue, pcp4;
    logic [5:0]  op_wb;

    logic [31:0] rdat1, rdat2, fwd_data, retired;
    logic        fwd_valid, halted;
    logic [4:0]  fwd_sel;

    logic [31:0] nb_rdat1, nb_rdat2, nb_fwd_data, nb_retired;
    logic        nb_fwd_valid, nb_halted;
    logic [4:0]  nb_fwd_sel;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_retired;

    always #5 CLK = ~CLK;

    writeback_unit #(.BYPASS(1'b1)) dut (
        .CLK(CLK), .RST(RST), .wb_valid(wb_valid), .regWr(regWr), .wsel(wsel),
        .MemToReg(MemToReg), .dmemload(dmemload), .portO(portO),
        .luiValue(luiValue), .pcp4(pcp4), .halt(halt), .op_wb(op_wb),
        .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
        .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
        .halted(halted), .retired(retired)
    );

    writeback_unit #(.BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RST(RST), .wb_valid(wb_valid), .regWr(regWr), .wsel(wsel),
        .MemToReg(MemToReg), .dmemload(dmemload), .portO(portO),
        .luiValue(luiValue), .pcp4(pcp4), .halt(halt), .op_wb(op_wb),
        .rsel1(rsel1), .rsel2(rsel2), .rdat1(nb_rdat1), .rdat2(nb_rdat2),
        .fwd_valid(nb_fwd_valid), .fwd_sel(nb_fwd_sel), .fwd_data(nb_fwd_data),
        .halted(nb_halted), .retired(nb_retired)
    );

    task automatic drive_idle();
        wb_valid = 1'b0;
        regWr    = 1'b0;
        halt     = 1'b0;
        wsel     = 5'd0;
        MemToReg = 2'b00;
        op_wb    = 6'd0;
    endtask

    // Present one instruction; the chosen source carries val, the others carry filler.
    task automatic drive_instr(input logic wr, input logic [4:0] sel,
                               input logic [1:0] mts, input logic [31:0] val,
                               input logic is_halt);
        wb_valid = 1'b1;
        regWr    = wr;
        wsel     = sel;
        MemToReg = mts;
        halt     = is_halt;
        op_wb    = is_halt ? 6'h3F : 6'h00;
        portO    = (mts == 2'b00) ? val : 32'hA0A0A0A0;
        dmemload = (mts == 2'b01) ? val : 32'hB1B1B1B1;
        luiValue = (mts == 2'b10) ? val : 32'hC2C2C2C2;
        pcp4     = (mts == 2'b11) ? val : 32'hD3D3D3D3;
        $display("txn: t=%0t wr=%0b wsel=%0d sel=%0d val=%h halt=%0b",
                 $time, wr, sel, mts, val, is_halt);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive_idle();
        rsel1 = 5'd0; rsel2 = 5'd0;
        portO = '0; dmemload = '0; luiValue = '0; pcp4 = '0;
        #1;
        checks++;
        if (halted !== 1'b0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: halted=%b retired=%h required 0/0", halted, retired);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rsel1 = 5'(r);
            rsel2 = 5'(31 - r);
            #1;
            checks++;
            if (rdat1 !== 32'd0 || rdat2 !== 32'd0 || nb_rdat1 !== 32'd0) begin
                errors++;
                $display("FAIL reset_read r%0d: rdat1=%h rdat2=%h nb=%h required 0",
                         r, rdat1, rdat2, nb_rdat1);
            end
        end
        exp_retired = 32'd0;
    endtask

    task automatic test_bypass();
        @(negedge CLK);
        drive_instr(1'b1, 5'd5, 2'b01, 32'hDEADBEEF, 1'b0);
        rsel1 = 5'd5;
        #1;
        checks++;
        if (rdat1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_pre: rdat1=%h required DEADBEEF", rdat1);
        end
        checks++;
        if (nb_rdat1 !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_pre: rdat1=%h required 00000000", nb_rdat1);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_sel !== 5'd5 || fwd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fwd_tap: valid=%b sel=%0d data=%h required 1/5/DEADBEEF",
                     fwd_valid, fwd_sel, fwd_data);
        end
        @(posedge CLK);
        #1;
        drive_idle();
        exp_retired = exp_retired + 1;
        #1;
        checks++;
        if (rdat1 !== 32'hDEADBEEF || nb_rdat1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_post: rdat1=%h nb=%h required DEADBEEF", rdat1, nb_rdat1);
        end
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL retire_count: retired=%h required %h", retired, exp_retired);
        end
    endtask

    task automatic test_mux_sweep();
        logic [31:0] src [4];
        src[0] = 32'h11111111; src[1] = 32'h22222222;
        src[2] = 32'h33333333; src[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive_instr(1'b1, 5'(i + 1), 2'(i), src[i], 1'b0);
            #1;
            checks++;
            if (fwd_data !== src[i]) begin
                errors++;
                $display("FAIL mux_sel%0d: fwd_data=%h required %h", i, fwd_data, src[i]);
            end
            @(posedge CLK);
            exp_retired = exp_retired + 1;
        end
        @(negedge CLK);
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            rsel1 = 5'(i + 1);
            rsel2 = 5'(i + 1);
            #1;
            checks++;
            if (rdat1 !== src[i] || rdat2 !== src[i]) begin
                errors++;
                $display("FAIL mux_reg%0d: rdat1=%h rdat2=%h required %h",
                         i + 1, rdat1, rdat2, src[i]);
            end
        end
    endtask

    task automatic test_reg0();
        @(negedge CLK);
        drive_instr(1'b1, 5'd0, 2'b00, 32'hFFFFFFFF, 1'b0);
        rsel1 = 5'd0;
        #1;
        checks++;
        if (fwd_valid !== 1'b0 || rdat1 !== 32'd0) begin
            errors++;
            $display("FAIL reg0_write: fwd_valid=%b rdat1=%h required 0/0", fwd_valid, rdat1);
        end
        @(posedge CLK);
        exp_retired = exp_retired + 1;
        #1;
        drive_idle();
        #1;
        checks++;
        if (rdat1 !== 32'd0) begin
            errors++;
            $display("FAIL reg0_read: rdat1=%h required 0", rdat1);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        drive_instr(1'b1, 5'd10, 2'b00, 32'h0000AAAA, 1'b0);
        @(negedge CLK);
        exp_retired = exp_retired + 1;
        drive_instr(1'b1, 5'd11, 2'b11, 32'h0000BBBB, 1'b0);
        rsel1 = 5'd10;
        rsel2 = 5'd11;
        #1;
        checks++;
        if (rdat1 !== 32'h0000AAAA || rdat2 !== 32'h0000BBBB) begin
            errors++;
            $display("FAIL b2b_bypass: rdat1=%h rdat2=%h required 0000AAAA/0000BBBB",
                     rdat1, rdat2);
        end
        checks++;
        if (nb_rdat2 !== 32'h0) begin
            errors++;
            $display("FAIL b2b_nobypass: rdat2=%h required 00000000", nb_rdat2);
        end
        rsel1 = 5'd11;
        #1;
        checks++;
        if (rdat1 !== 32'h0000BBBB || rdat1 !== rdat2) begin
            errors++;
            $display("FAIL equal_sel: rdat1=%h rdat2=%h required 0000BBBB", rdat1, rdat2);
        end
        @(posedge CLK);
        exp_retired = exp_retired + 1;
        #1;
        drive_idle();
        #1;
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL b2b_retired: retired=%h required %h", retired, exp_retired);
        end
    endtask

    task automatic test_wrap();
        @(negedge CLK);
        force dut.r_retired = 32'hFFFFFFFF;
        @(posedge CLK);
        #1;
        release dut.r_retired;
        #1;
        drive_instr(1'b0, 5'd0, 2'b00, 32'h0, 1'b0);
        @(posedge CLK);
        #1;
        drive_idle();
        checks++;
        if (retired !== 32'h00000000) begin
            errors++;
            $display("FAIL retired_wrap: retired=%h required 00000000", retired);
        end
    endtask

    task automatic test_reset_midwrite();
        @(negedge CLK);
        drive_instr(1'b1, 5'd9, 2'b00, 32'h12345678, 1'b0);
        #2;
        RST = 1'b1;
        rsel1 = 5'd5;
        rsel2 = 5'd1;
        #1;
        checks++;
        if (rdat1 !== 32'd0 || rdat2 !== 32'd0 || retired !== 32'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdat1=%h rdat2=%h retired=%h halted=%b required 0",
                     rdat1, rdat2, retired, halted);
        end
        @(negedge CLK);
        drive_idle();
        RST = 1'b0;
        rsel1 = 5'd9;
        #1;
        checks++;
        if (rdat1 !== 32'd0 || nb_rdat1 !== 32'd0) begin
            errors++;
            $display("FAIL lost_write: reg9=%h nb=%h required 0", rdat1, nb_rdat1);
        end
        exp_retired = 32'd0;
    endtask

    task automatic test_halt();
        @(negedge CLK);
        drive_instr(1'b1, 5'd3, 2'b00, 32'h00000055, 1'b0);
        @(negedge CLK);
        exp_retired = exp_retired + 1;
        drive_instr(1'b1, 5'd7, 2'b00, 32'h00000ABC, 1'b1);
        #1;
        checks++;
        if (halted !== 1'b0 || fwd_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_pre: halted=%b fwd_valid=%b required 0/1", halted, fwd_valid);
        end
        @(posedge CLK);
        exp_retired = exp_retired + 1;
        #1;
        checks++;
        if (halted !== 1'b1 || retired !== exp_retired) begin
            errors++;
            $display("FAIL halt_post: halted=%b retired=%h required 1/%h",
                     halted, retired, exp_retired);
        end
        @(negedge CLK);
        drive_instr(1'b1, 5'd8, 2'b01, 32'h00001234, 1'b0);
        rsel2 = 5'd8;
        #1;
        checks++;
        if (fwd_valid !== 1'b0 || rdat2 !== 32'd0) begin
            errors++;
            $display("FAIL halted_write: fwd_valid=%b rdat2=%h required 0/0", fwd_valid, rdat2);
        end
        @(posedge CLK);
        #1;
        drive_idle();
        @(negedge CLK);
        rsel1 = 5'd7;
        rsel2 = 5'd8;
        #1;
        checks++;
        if (rdat1 !== 32'h00000ABC || rdat2 !== 32'd0) begin
            errors++;
            $display("FAIL halt_regs: r7=%h r8=%h required 00000ABC/0", rdat1, rdat2);
        end
        checks++;
        if (retired !== exp_retired || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_frozen: retired=%h halted=%b required %h/1",
                     retired, halted, exp_retired);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bypass();
        test_mux_sweep();
        test_reg0();
        test_back_to_back();
        test_wrap();
        test_reset_midwrite();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
